// File: rtl/lsu_dmem_ctrl_pkg.sv
// Shared LSU definitions: access-size codes, FSM state encoding and byte-lane mask helper.
package npc_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_t;

  // Unshifted byte-enable pattern for an access size; the illegal size enables no lanes.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = 4'b0001;
      SZ_H:    size_mask = 4'b0011;
      SZ_W:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_if.sv
// Core-side request/response bus and RAM data-port bus of the load/store unit.
interface lsu_core_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_dmem_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              dmem_ren;
  logic [ADDR_W-1:0] dmem_raddr;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_wen;
  logic [ADDR_W-1:0] dmem_waddr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_wstrb;

  modport master (
    output dmem_ren, dmem_raddr, dmem_wen, dmem_waddr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata
  );
  modport slave (
    input  dmem_ren, dmem_raddr, dmem_wen, dmem_waddr, dmem_wdata, dmem_wstrb,
    output dmem_rdata
  );
endinterface

// File: rtl/lsu_dmem_ctrl_load_align.sv
// Combinational load aligner: selects the addressed byte/half of a RAM word and extends it.
module lsu_load_align
  import npc_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_B:    data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      SZ_W:    data_o = shifted;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store front-end: one request at a time, alignment check, single-cycle RAM access, held response.
module lsu_dmem_ctrl
  import npc_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  lsu_core_if.slave     core,
  lsu_dmem_if.master    dmem
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              wen_q, wen_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req_err;
  logic [1:0]        off;
  logic [31:0]       load_data;
  logic [31:0]       wrep;
  logic [3:0]        strb;

  assign off = addr_q[1:0];

  always_comb begin
    case (core.req_size)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = core.req_addr[0];
      SZ_W:    req_err = |core.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata_i    (dmem.dmem_rdata),
    .off_i      (off),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  // Replicating the store data across lanes lets one shift place it under any strobe pattern.
  always_comb begin
    case (size_q)
      SZ_B:    wrep = {4{wdata_q[7:0]}};
      SZ_H:    wrep = {2{wdata_q[15:0]}};
      default: wrep = wdata_q;
    endcase
  end

  assign strb = size_mask(size_q) << off;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    size_d          = size_q;
    wen_d           = wen_q;
    uns_d           = uns_q;
    err_d           = err_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    core.req_ready  = 1'b0;
    core.resp_valid = 1'b0;
    core.resp_rdata = '0;
    core.resp_err   = 1'b0;
    dmem.dmem_ren   = 1'b0;
    dmem.dmem_raddr = '0;
    dmem.dmem_wen   = 1'b0;
    dmem.dmem_waddr = '0;
    dmem.dmem_wdata = '0;
    dmem.dmem_wstrb = '0;
    case (state_q)
      IDLE: begin
        core.req_ready = reset;
        if (core.req_valid && reset) begin
          addr_d  = core.req_addr;
          size_d  = core.req_size;
          wen_d   = core.req_wen;
          uns_d   = core.req_unsigned;
          wdata_d = core.req_wdata;
          err_d   = req_err;
          rdata_d = '0;
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        dmem.dmem_raddr = {addr_q[ADDR_W-1:2], 2'b00};
        dmem.dmem_waddr = {addr_q[ADDR_W-1:2], 2'b00};
        // Enables are gated by reset so a store caught by reset never reaches the RAM.
        if (wen_q) begin
          dmem.dmem_wen   = reset;
          dmem.dmem_wdata = wrep << {off, 3'b000};
          dmem.dmem_wstrb = {{(DATA_W-4){1'b0}}, strb};
        end else begin
          dmem.dmem_ren   = reset;
          rdata_d         = load_data;
        end
        state_d = RESP;
      end
      RESP: begin
        core.resp_valid = 1'b1;
        core.resp_rdata = rdata_q;
        core.resp_err   = err_q;
        if (core.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
